rr_arbiter_q: RTL and testbench

Round-robin arbiter with per-grant hold quantum, sharing one resource among `N` requesters. Successor to the two-requester grant FSM. It adds fair rotation, burst holding while a requester keeps `req` asserted, and forced hand-off after `QUANTUM` cycles when others are waiting. It sits between requesting masters and the shared resource; `gnt` drives the resource mux select and requester acknowledge.

---
 rtl/rr_arbiter_q.sv | 142 ++++++++++++++
 tb/tb_rr_arbiter_q.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_q.sv
// Round-robin arbiter with a per-grant hold quantum: owners keep the resource while
// requesting, but are forced to hand off after QUANTUM cycles if anyone else waits.
module rr_arbiter_q #(
    parameter int N       = 4,
    parameter int QUANTUM = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 gnt_valid
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(QUANTUM + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]   gnt_id_q, gnt_id_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic [N-1:0]    others_s;
    logic [IW-1:0]   win_req_s;
    logic [IW-1:0]   win_oth_s;

    // First set bit of cand, scanning from ptr+1 upward and wrapping back to ptr.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] cand,
                                               input logic [IW-1:0] ptr);
        logic [IW-1:0] pick;
        logic [IW-1:0] idx_l;
        logic          found;
        int            idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx   = (int'(ptr) + k) % N;
            idx_l = IW'(idx);
            if (!found && cand[idx_l]) begin
                pick  = idx_l;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    assign others_s  = req & ~(N'(1'b1) << owner_q);
    assign win_req_s = rr_pick(req, last_q);
    assign win_oth_s = rr_pick(others_s, last_q);

    // State and registered-output flops; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            last_q      <= IW'(N - 1);
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    // Next-state: release takes precedence over preemption; both rotate the pointer.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    state_d    = GRANT;
                    owner_d    = win_req_s;
                    last_d     = win_req_s;
                    hold_cnt_d = CW'(1'b1);
                end else begin
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!req[owner_q]) begin
                    if (others_s == '0) begin
                        state_d    = IDLE;
                        hold_cnt_d = '0;
                    end else begin
                        owner_d    = win_oth_s;
                        last_d     = win_oth_s;
                        hold_cnt_d = CW'(1'b1);
                    end
                end else if ((hold_cnt_q >= CW'(QUANTUM)) && (others_s != '0)) begin
                    owner_d    = win_oth_s;
                    last_d     = win_oth_s;
                    hold_cnt_d = CW'(1'b1);
                end else if (hold_cnt_q < CW'(QUANTUM)) begin
                    hold_cnt_d = hold_cnt_q + CW'(1'b1);
                end else begin
                    hold_cnt_d = hold_cnt_q;
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Output decode from the next state so gnt/gnt_id/gnt_valid come straight off flops.
    always_comb begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_id_d    = owner_d;
        if (state_d == GRANT) begin
            gnt_d       = N'(1'b1) << owner_d;
            gnt_valid_d = 1'b1;
        end else begin
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter_q.sv
// Bench for rr_arbiter_q: two instances (QUANTUM=2 and 8) share stimulus; a queue-of-owners
// style reference model checks every cycle, plus table-driven and directed sequences.
module tb_rr_arbiter_q;
    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt2, gnt8;
    logic [1:0] id2, id8;
    logic       v2, v8;

    int checks;
    int failures;

    rr_arbiter_q #(.N(4), .QUANTUM(2)) dut_q2 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt2), .gnt_id(id2), .gnt_valid(v2)
    );
    rr_arbiter_q #(.N(4), .QUANTUM(8)) dut_q8 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt8), .gnt_id(id8), .gnt_valid(v8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner (-1 = nobody), rotation pointer, unbounded run length.
    int m_owner[2];
    int m_last[2];
    int m_run[2];
    int m_quant[2];
    logic m_in_reset;

    function automatic int pick(input logic [3:0] c, input int last);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (last + k) % 4;
            if (c[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] rq);
        m_in_reset = !r;
        for (int d = 0; d < 2; d++) begin
            logic [3:0] oth;
            int w;
            if (!r) begin
                m_owner[d] = -1;
                m_last[d]  = 3;
                m_run[d]   = 0;
            end else if (m_owner[d] < 0) begin
                if (rq != 4'b0000) begin
                    w = pick(rq, m_last[d]);
                    m_owner[d] = w; m_last[d] = w; m_run[d] = 1;
                end
            end else begin
                oth = rq;
                oth[m_owner[d]] = 1'b0;
                if (!rq[m_owner[d]]) begin
                    if (oth == 4'b0000) begin
                        m_owner[d] = -1; m_run[d] = 0;
                    end else begin
                        w = pick(oth, m_last[d]);
                        m_owner[d] = w; m_last[d] = w; m_run[d] = 1;
                    end
                end else if (m_run[d] >= m_quant[d] && oth != 4'b0000) begin
                    w = pick(oth, m_last[d]);
                    m_owner[d] = w; m_last[d] = w; m_run[d] = 1;
                end else begin
                    m_run[d] = m_run[d] + 1;
                end
            end
        end
    endtask

    task automatic check_models();
        for (int d = 0; d < 2; d++) begin
            int eg, ag, av, ai;
            eg = (m_owner[d] < 0) ? 0 : (1 << m_owner[d]);
            ag = (d == 0) ? int'(gnt2) : int'(gnt8);
            av = (d == 0) ? int'(v2) : int'(v8);
            ai = (d == 0) ? int'(id2) : int'(id8);
            chk(d == 0 ? "model_gnt_q2" : "model_gnt_q8", ag, eg);
            chk(d == 0 ? "model_valid_q2" : "model_valid_q8", av, (m_owner[d] >= 0) ? 1 : 0);
            if (m_owner[d] >= 0)
                chk(d == 0 ? "model_id_q2" : "model_id_q8", ai, m_owner[d]);
            else if (m_in_reset)
                chk(d == 0 ? "reset_id_q2" : "reset_id_q8", ai, 0);
        end
    endtask

    // One clock: drive away from the edge, advance the model at the edge, sample 1 later.
    task automatic cycle(input logic r, input logic [3:0] rq);
        rst_n = r;
        req   = rq;
        @(posedge clk);
        model_step(r, rq);
        #1;
        check_models();
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       v;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [3:0] rq;
        logic       r;
        checks     = 0;
        failures   = 0;
        m_quant[0] = 2;
        m_quant[1] = 8;
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1; m_last[d] = 3; m_run[d] = 0;
        end
        m_in_reset = 1'b1;
        rst_n = 1'b0;
        req   = 4'b0000;

        // Expected values below are for the QUANTUM=2 instance.
        repeat (3) tbl.push_back('{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0});
        repeat (2) tbl.push_back('{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0});
        repeat (5) tbl.push_back('{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1});
        tbl.push_back('{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1});
        tbl.push_back('{1'b1, 4'b1111, 4'b0010, 2'd1, 1'b1});
        tbl.push_back('{1'b1, 4'b1111, 4'b0010, 2'd1, 1'b1});
        tbl.push_back('{1'b1, 4'b1111, 4'b0100, 2'd2, 1'b1});
        tbl.push_back('{1'b1, 4'b1111, 4'b0100, 2'd2, 1'b1});
        tbl.push_back('{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1});
        tbl.push_back('{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1});
        tbl.push_back('{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1});
        tbl.push_back('{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1});

        foreach (tbl[i]) begin
            cycle(tbl[i].rst, tbl[i].req);
            chk("tbl_gnt", int'(gnt2), int'(tbl[i].gnt));
            chk("tbl_valid", int'(v2), int'(tbl[i].v));
            if (tbl[i].v || !tbl[i].rst)
                chk("tbl_id", int'(id2), int'(tbl[i].id));
        end

        // Hand-off from owner 1 to requester 3 with no idle bubble.
        cycle(1'b0, 4'b0000);
        cycle(1'b1, 4'b0010);
        chk("handoff_own1", int'(gnt2), 4'b0010);
        cycle(1'b1, 4'b1010);
        chk("handoff_hold", int'(gnt2), 4'b0010);
        cycle(1'b1, 4'b1000);
        chk("handoff_gnt", int'(gnt2), 4'b1000);
        chk("handoff_valid", int'(v2), 1);
        chk("handoff_id", int'(id2), 3);

        // Uncontested hold then late contention on the QUANTUM=8 instance.
        cycle(1'b0, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 4'b0001);
            chk("uncontested_gnt", int'(gnt8), 4'b0001);
        end
        cycle(1'b1, 4'b1001);
        chk("late_preempt_gnt", int'(gnt8), 4'b1000);
        chk("late_preempt_id", int'(id8), 3);

        // Reset while owner 2 is mid-quantum; search restarts from index 0.
        cycle(1'b0, 4'b0000);
        cycle(1'b1, 4'b0100);
        cycle(1'b1, 4'b0110);
        chk("midrst_owner2", int'(gnt8), 4'b0100);
        cycle(1'b0, 4'b0110);
        chk("midrst_gnt_q8", int'(gnt8), 4'b0000);
        chk("midrst_valid_q8", int'(v8), 0);
        chk("midrst_gnt_q2", int'(gnt2), 4'b0000);
        cycle(1'b1, 4'b0110);
        chk("postrst_gnt_q8", int'(gnt8), 4'b0010);
        chk("postrst_gnt_q2", int'(gnt2), 4'b0010);

        // Randomized sticky requests with occasional reset, checked against the model.
        rq = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(3) == 0) rq[b] = ~rq[b];
            r = ($urandom_range(59) != 0);
            cycle(r, rq);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
